lcd_timing_gen: RTL and testbench

- Parametrised RGB LCD timing engine; next generation of the fixed 800x480 lcd_driver.
- Sits between the lcd_clk domain (PLL output, gated by lock) and a pixel source such as lcd_display or a framebuffer reader.
- Generates HS/VS/DE with per-panel porch/sync geometry and programmable sync polarity.
- Issues pixel coordinates one cycle ahead of DE; adds frame-boundary run/stop control, frame/line strobes and a registered RGB output.

---
 rtl/lcd_pkg.sv | 81 ++++++++
 rtl/lcd_scan_cnt.sv | 71 +++++++
 rtl/lcd_timing_gen.sv | 138 +++++++++++++
 tb/tb_lcd_timing_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD timing engine: panel timing sets,
// bar colours for RGB565/RGB888 and the scan state encoding.
package lcd_pkg;

    typedef struct packed {
        int unsigned h_sync;
        int unsigned h_back;
        int unsigned h_disp;
        int unsigned h_front;
        int unsigned v_sync;
        int unsigned v_back;
        int unsigned v_disp;
        int unsigned v_front;
    } lcd_timing_t;

    localparam lcd_timing_t T_480X272 = '{
        h_sync: 41, h_back: 2, h_disp: 480, h_front: 2,
        v_sync: 10, v_back: 2, v_disp: 272, v_front: 2
    };

    localparam lcd_timing_t T_800X480 = '{
        h_sync: 128, h_back: 88, h_disp: 800, h_front: 40,
        v_sync: 2, v_back: 33, v_disp: 480, v_front: 10
    };

    localparam lcd_timing_t T_1024X600 = '{
        h_sync: 20, h_back: 140, h_disp: 1024, h_front: 160,
        v_sync: 3, v_back: 20, v_disp: 600, v_front: 12
    };

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } scan_state_t;

    localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB565_BLACK   = 16'h0000;
    localparam logic [15:0] RGB565_RED     = 16'hF800;
    localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE    = 16'h001F;
    localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;

    localparam logic [23:0] RGB888_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB888_BLACK   = 24'h000000;
    localparam logic [23:0] RGB888_RED     = 24'hFF0000;
    localparam logic [23:0] RGB888_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB888_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB888_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB888_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB888_YELLOW  = 24'hFFFF00;

    // Colour-bar order, left to right across the active line.
    function automatic logic [15:0] bar_rgb565(input logic [2:0] idx);
        case (idx)
            3'd0: return RGB565_WHITE;
            3'd1: return RGB565_BLACK;
            3'd2: return RGB565_RED;
            3'd3: return RGB565_GREEN;
            3'd4: return RGB565_BLUE;
            3'd5: return RGB565_CYAN;
            3'd6: return RGB565_MAGENTA;
            default: return RGB565_YELLOW;
        endcase
    endfunction

    function automatic logic [23:0] bar_rgb888(input logic [2:0] idx);
        case (idx)
            3'd0: return RGB888_WHITE;
            3'd1: return RGB888_BLACK;
            3'd2: return RGB888_RED;
            3'd3: return RGB888_GREEN;
            3'd4: return RGB888_BLUE;
            3'd5: return RGB888_CYAN;
            3'd6: return RGB888_MAGENTA;
            default: return RGB888_YELLOW;
        endcase
    endfunction

endpackage

// File: rtl/lcd_scan_cnt.sv
// Horizontal/vertical scan counters with IDLE/SCAN run gating; run is only
// honoured for stopping on the last clock of a frame.
module lcd_scan_cnt
    import lcd_pkg::*;
#(
    parameter int unsigned H_TOTAL = 1056,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned CW      = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] v_cnt,
    output logic          scan,
    output logic          h_last
);

    localparam logic [CW-1:0] H_MAX = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_MAX = CW'(V_TOTAL - 1);

    scan_state_t state;
    scan_state_t state_nxt;
    logic        v_last;
    logic        frame_last;

    assign h_last     = (h_cnt == H_MAX);
    assign v_last     = (v_cnt == V_MAX);
    assign frame_last = h_last && v_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (run)                state_nxt = ST_SCAN;
            ST_SCAN: if (frame_last && !run) state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        scan = 1'b0;
        if (state == ST_SCAN) begin
            scan = 1'b1;
        end
    end

    // Counters sit at (0,0) in IDLE, so the first SCAN clock is frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!scan) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// Parametrised RGB LCD timing engine: registered HS/VS/DE/RGB, look-ahead pixel
// requests and frame/line strobes. Colour bars are built with LCD_TEST_PATTERN_EN.
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int unsigned H_SYNC  = T_800X480.h_sync,
    parameter int unsigned H_BACK  = T_800X480.h_back,
    parameter int unsigned H_DISP  = T_800X480.h_disp,
    parameter int unsigned H_FRONT = T_800X480.h_front,
    parameter int unsigned V_SYNC  = T_800X480.v_sync,
    parameter int unsigned V_BACK  = T_800X480.v_back,
    parameter int unsigned V_DISP  = T_800X480.v_disp,
    parameter int unsigned V_FRONT = T_800X480.v_front,
    parameter bit          HS_POL  = 1'b0,
    parameter bit          VS_POL  = 1'b0,
    parameter int unsigned DW      = 16,
    parameter int unsigned CW      = 11
) (
    input  logic          lcd_clk,
    input  logic          sys_rst_n,
    input  logic          run,
`ifdef LCD_TEST_PATTERN_EN
    input  logic          pattern_en,
`endif
    input  logic [DW-1:0] pixel_data,
    output logic [CW-1:0] pixel_xpos,
    output logic [CW-1:0] pixel_ypos,
    output logic          pixel_req,
    output logic          frame_start,
    output logic          line_end,
    output logic          lcd_hs,
    output logic          lcd_vs,
    output logic          lcd_de,
    output logic [DW-1:0] lcd_rgb,
    output logic          lcd_bl,
    output logic          lcd_rst,
    output logic          lcd_pclk
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int unsigned HA      = H_SYNC + H_BACK;
    localparam int unsigned VA      = V_SYNC + V_BACK;

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [31:0]   hx;
    logic [31:0]   vx;
    logic          scan;
    logic          h_last;
    logic          h_act;
    logic          v_act;
    logic          h_req;
    logic          de_nxt;
    logic [DW-1:0] rgb_src;

    lcd_scan_cnt #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .CW      (CW)
    ) u_scan_cnt (
        .clk    (lcd_clk),
        .rst_n  (sys_rst_n),
        .run    (run),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .scan   (scan),
        .h_last (h_last)
    );

    assign hx = 32'(h_cnt);
    assign vx = 32'(v_cnt);

    assign h_act  = (hx >= HA) && (hx < HA + H_DISP);
    assign v_act  = (vx >= VA) && (vx < VA + V_DISP);
    assign de_nxt = scan && h_act && v_act;

    // Requests lead the counter window by one clock so a registered pixel
    // source has its data ready when the RGB register samples it.
    assign h_req     = (hx + 1 >= HA) && (hx + 1 < HA + H_DISP);
    assign pixel_req = scan && h_req && v_act;
    assign pixel_xpos = pixel_req ? CW'(hx + 1 - HA) : '0;
    assign pixel_ypos = pixel_req ? CW'(vx - VA) : '0;

    assign frame_start = scan && (h_cnt == '0) && (v_cnt == '0);
    assign line_end    = scan && h_last;
    assign lcd_pclk    = lcd_clk;

`ifdef LCD_TEST_PATTERN_EN
    localparam int unsigned BAR_W = (H_DISP >= 8) ? H_DISP / 8 : 1;

    logic          pat_on;
    logic [31:0]   bar_num;
    logic [2:0]    bar_idx;
    logic [DW-1:0] bar_rgb;

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pat_on <= 1'b0;
        end else if (frame_start) begin
            pat_on <= pattern_en;
        end
    end

    // Column is taken from the counter being registered into DE this clock.
    assign bar_num = (hx - HA) / BAR_W;
    assign bar_idx = (bar_num < 32'd8) ? bar_num[2:0] : 3'd7;

    if (DW == 24) begin : g_bar888
        assign bar_rgb = DW'(bar_rgb888(bar_idx));
    end else begin : g_bar565
        assign bar_rgb = DW'(bar_rgb565(bar_idx));
    end

    assign rgb_src = pat_on ? bar_rgb : pixel_data;
`else
    assign rgb_src = pixel_data;
`endif

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lcd_hs  <= ~HS_POL;
            lcd_vs  <= ~VS_POL;
            lcd_de  <= 1'b0;
            lcd_rgb <= '0;
            lcd_bl  <= 1'b0;
            lcd_rst <= 1'b0;
        end else begin
            lcd_hs  <= (scan && hx < H_SYNC) ? HS_POL : ~HS_POL;
            lcd_vs  <= (scan && vx < V_SYNC) ? VS_POL : ~VS_POL;
            lcd_de  <= de_nxt;
            lcd_rgb <= de_nxt ? rgb_src : '0;
            lcd_bl  <= 1'b1;
            lcd_rst <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a 15x8 miniature raster, with a second
// instance using inverted sync polarity. Pattern checks need LCD_TEST_PATTERN_EN.
module tb_lcd_timing_gen;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        pattern_en;
    logic [15:0] pixel_data;
    logic [15:0] pd_hold;

    logic [3:0]  xpos, ypos, p_xpos, p_ypos;
    logic        req, fs, le, hs, vs, de, bl, lrst, pclk;
    logic        p_req, p_fs, p_le, p_hs, p_vs, p_de, p_bl, p_lrst, p_pclk;
    logic [15:0] rgb, p_rgb;

    logic [15:0] bars [8];
    int          n_pass;
    int          n_total;

    lcd_timing_gen #(
        .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .DW(16), .CW(4)
    ) dut (
        .lcd_clk     (clk),
        .sys_rst_n   (rst_n),
        .run         (run),
`ifdef LCD_TEST_PATTERN_EN
        .pattern_en  (pattern_en),
`endif
        .pixel_data  (pixel_data),
        .pixel_xpos  (xpos),
        .pixel_ypos  (ypos),
        .pixel_req   (req),
        .frame_start (fs),
        .line_end    (le),
        .lcd_hs      (hs),
        .lcd_vs      (vs),
        .lcd_de      (de),
        .lcd_rgb     (rgb),
        .lcd_bl      (bl),
        .lcd_rst     (lrst),
        .lcd_pclk    (pclk)
    );

    lcd_timing_gen #(
        .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .DW(16), .CW(4)
    ) dut_p (
        .lcd_clk     (clk),
        .sys_rst_n   (rst_n),
        .run         (run),
`ifdef LCD_TEST_PATTERN_EN
        .pattern_en  (pattern_en),
`endif
        .pixel_data  (pixel_data),
        .pixel_xpos  (p_xpos),
        .pixel_ypos  (p_ypos),
        .pixel_req   (p_req),
        .frame_start (p_fs),
        .line_end    (p_le),
        .lcd_hs      (p_hs),
        .lcd_vs      (p_vs),
        .lcd_de      (p_de),
        .lcd_rgb     (p_rgb),
        .lcd_bl      (p_bl),
        .lcd_rst     (p_lrst),
        .lcd_pclk    (p_pclk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, got time %0t required < 1000000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int c, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s (c=%0d): observed %0h expected %0h", tag, c, got, exp);
    endtask

    // Registered pixel source: presents the coordinate requested one clock earlier.
    task automatic tick();
        @(negedge clk);
        pixel_data = pd_hold;
        pd_hold    = {4'h0, xpos, 4'h0, ypos};
    endtask

    // Called on the frame_start clock; checks every clock of one 120-clock frame.
    task automatic run_frame(input int drop_at, input int pe_at, input bit pat);
        int de_cnt, hs_cnt, vs_cnt, k;
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; k = 0;
        for (int c = 0; c < 120; c++) begin
            int h, v, hp, vp;
            bit req_e, de_e, hs_e, vs_e;
            logic [15:0] rgb_e;
            h  = c % 15;
            v  = c / 15;
            hp = (c == 0) ? 14 : (c - 1) % 15;
            vp = (c == 0) ? 7 : (c - 1) / 15;
            req_e = (v >= 3) && (v < 7) && (h >= 4) && (h < 12);
            de_e  = (vp >= 3) && (vp < 7) && (hp >= 5) && (hp < 13);
            hs_e  = (c > 0) && (hp < 2);
            vs_e  = (c > 0) && (vp < 1);
            rgb_e = 16'h0000;
            if (de_e) begin
                rgb_e = pat ? bars[k % 8] : {8'(k % 8), 8'(k / 8)};
                k++;
            end
            check("frame_start", c, 32'(fs), 32'(c == 0));
            check("line_end", c, 32'(le), 32'(h == 14));
            check("pixel_req", c, 32'(req), 32'(req_e));
            check("pixel_xpos", c, 32'(xpos), req_e ? 32'(h - 4) : 32'd0);
            check("pixel_ypos", c, 32'(ypos), req_e ? 32'(v - 3) : 32'd0);
            check("lcd_de", c, 32'(de), 32'(de_e));
            check("lcd_rgb", c, 32'(rgb), 32'(rgb_e));
            check("lcd_hs", c, 32'(hs), 32'(!hs_e));
            check("lcd_vs", c, 32'(vs), 32'(!vs_e));
            check("pol_hs", c, 32'(p_hs), 32'(hs_e));
            check("pol_vs", c, 32'(p_vs), 32'(vs_e));
            check("pol_de", c, 32'(p_de), 32'(de_e));
            if (de === 1'b1) de_cnt++;
            if (hs === 1'b0) hs_cnt++;
            if (vs === 1'b0) vs_cnt++;
            if (c == drop_at) run = 1'b0;
            if (c == pe_at) pattern_en = ~pattern_en;
            tick();
        end
        check("de_per_frame", 120, 32'(de_cnt), 32'd32);
        check("hs_per_frame", 120, 32'(hs_cnt), 32'd16);
        check("vs_per_frame", 120, 32'(vs_cnt), 32'd15);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; run = 1'b0; pattern_en = 1'b0;
        pixel_data = '0; pd_hold = '0;
        bars = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0,
                 16'h001F, 16'h07FF, 16'hF81F, 16'hFFE0};

        // Reset state
        repeat (3) tick();
        check("rst_hs", 0, 32'(hs), 32'd1);
        check("rst_vs", 0, 32'(vs), 32'd1);
        check("rst_pol_hs", 0, 32'(p_hs), 32'd0);
        check("rst_pol_vs", 0, 32'(p_vs), 32'd0);
        check("rst_de", 0, 32'(de), 32'd0);
        check("rst_rgb", 0, 32'(rgb), 32'd0);
        check("rst_req", 0, 32'(req), 32'd0);
        check("rst_fs", 0, 32'(fs), 32'd0);
        check("rst_le", 0, 32'(le), 32'd0);
        check("rst_bl", 0, 32'(bl), 32'd0);
        check("rst_lcd_rst", 0, 32'(lrst), 32'd0);

        // Release; IDLE with run low
        rst_n = 1'b1;
        tick();
        check("bl_after_rst", 0, 32'(bl), 32'd1);
        check("lcd_rst_after_rst", 0, 32'(lrst), 32'd1);
        repeat (4) tick();
        check("idle_fs", 0, 32'(fs), 32'd0);
        check("idle_req", 0, 32'(req), 32'd0);

        // Start scanning: frame_start on the next clock, then two checked frames
        run = 1'b1;
        tick();
        check("start_fs", 0, 32'(fs), 32'd1);
        run_frame(-1, -1, 1'b0);
        run_frame(40, -1, 1'b0);

        // Stopped at the frame boundary
        for (int i = 0; i < 10; i++) begin
            check("stop_fs", i, 32'(fs), 32'd0);
            check("stop_le", i, 32'(le), 32'd0);
            check("stop_hs", i, 32'(hs), 32'd1);
            check("stop_vs", i, 32'(vs), 32'd1);
            check("stop_pol_hs", i, 32'(p_hs), 32'd0);
            check("stop_de", i, 32'(de), 32'd0);
            check("stop_req", i, 32'(req), 32'd0);
            tick();
        end
        run = 1'b1;
        tick();
        check("restart_fs", 0, 32'(fs), 32'd1);

        // Asynchronous reset during active video (line 4, column 0 on de)
        repeat (66) tick();
        check("pre_rst_de", 66, 32'(de), 32'd1);
        check("pre_rst_rgb", 66, 32'(rgb), 32'h0001);
        #2 rst_n = 1'b0;
        #1;
        check("async_de", 0, 32'(de), 32'd0);
        check("async_rgb", 0, 32'(rgb), 32'd0);
        check("async_bl", 0, 32'(bl), 32'd0);
        check("async_lcd_rst", 0, 32'(lrst), 32'd0);
        check("async_hs", 0, 32'(hs), 32'd1);
        check("async_fs", 0, 32'(fs), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rerelease_bl", 0, 32'(bl), 32'd1);
        check("rerelease_fs", 0, 32'(fs), 32'd1);
        run_frame(-1, -1, 1'b0);

`ifdef LCD_TEST_PATTERN_EN
        // pattern_en raised mid-frame: takes effect only from the next frame
        run_frame(-1, 40, 1'b0);
        run_frame(-1, 40, 1'b1);
        run_frame(-1, -1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
